// File: rtl/led_pkg.sv
// Shared types for the LED frame sequencer.
//   mode_e  : per-frame pixel pattern (DOT / FILL / TAIL / OFF)
//   state_e : sequencer FSM states
//   color_t : 24-bit GRB colour, G in [23:16], R in [15:8], B in [7:0]
package led_pkg;

  typedef enum logic [1:0] {
    MODE_DOT  = 2'd0,
    MODE_FILL = 2'd1,
    MODE_TAIL = 2'd2,
    MODE_OFF  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LATCH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef logic [23:0] color_t;

  localparam color_t COLOR_OFF = 24'h000000;

endpackage

// File: rtl/led_driver.sv
// Single-pixel serial LED driver (WS2812-style one-wire line).
// A valid_in pulse while idle captures rgb_in and shifts its 24 bits out
// MSB first. Each bit occupies BIT_CYCLES clocks: the line is high for
// T1H_CYCLES for a '1' and T0H_CYCLES for a '0', low for the rest.
// finished_led pulses for one cycle after the last bit slot.
// Ports:
//   clk_in        clock
//   rst_in        asynchronous active-high reset
//   rgb_in        colour to send (captured on valid_in)
//   valid_in      start request, ignored while a pixel is in flight
//   signal_out    serial data line (registered)
//   finished_led  one-cycle end-of-pixel pulse
module led_driver
  import led_pkg::*;
#(
  parameter int BIT_CYCLES = 125,
  parameter int T0H_CYCLES = 40,
  parameter int T1H_CYCLES = 80
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  color_t rgb_in,
  input  logic   valid_in,
  output logic   signal_out,
  output logic   finished_led
);

  localparam int PHW = $clog2(BIT_CYCLES + 1);

  logic           active_q;
  color_t         shift_q;
  logic [4:0]     bit_cnt_q;
  logic [PHW-1:0] phase_q;
  logic           out_q;
  logic           fin_q;
  logic [PHW-1:0] high_len;

  assign high_len = shift_q[23] ? PHW'(T1H_CYCLES) : PHW'(T0H_CYCLES);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      active_q  <= 1'b0;
      shift_q   <= COLOR_OFF;
      bit_cnt_q <= '0;
      phase_q   <= '0;
      out_q     <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      fin_q <= 1'b0;
      if (!active_q) begin
        out_q <= 1'b0;
        if (valid_in) begin
          active_q  <= 1'b1;
          shift_q   <= rgb_in;
          bit_cnt_q <= 5'd23;
          phase_q   <= '0;
        end
      end else begin
        out_q <= (phase_q < high_len);
        if (phase_q == PHW'(BIT_CYCLES - 1)) begin
          phase_q <= '0;
          if (bit_cnt_q == 5'd0) begin
            active_q <= 1'b0;
            fin_q    <= 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q - 5'd1;
            shift_q   <= {shift_q[22:0], 1'b0};
          end
        end else begin
          phase_q <= phase_q + 1'b1;
        end
      end
    end
  end

  assign signal_out   = out_q;
  assign finished_led = fin_q;

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame sequencer for a strip of NUM_LEDS serial LEDs.
// On start_frame it snapshots position/colour/mode, feeds one pixel at a
// time to led_driver, then holds the line low for the latch gap and
// pulses frame_done.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start_frame, inputs are sampled on acceptance
// ST_LOAD  | one-cycle valid_in to the driver for pixel led_idx
// ST_WAIT  | pixel being shifted out, waiting for finished_led
// ST_LATCH | line held low for the latch gap
// ST_DONE  | frame_done pulse, busy already low
//
// Ports:
//   clk_100mhz        clock
//   sys_rst           asynchronous active-high reset
//   current_position  head index, 0-based (may exceed NUM_LEDS-1)
//   color_on          lit colour, GRB
//   mode              0 DOT, 1 FILL, 2 TAIL, 3 OFF
//   start_frame       frame request, level or pulse
//   signal_out        serial LED data line
//   busy              frame in progress
//   frame_done        one-cycle end-of-frame pulse
module led_frame_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = 10,
  parameter int TAIL_LEN     = 3,
  parameter int LATCH_CYCLES = 5000,
  parameter int BIT_CYCLES   = 125,
  parameter int T0H_CYCLES   = 40,
  parameter int T1H_CYCLES   = 80
) (
  input  logic                        clk_100mhz,
  input  logic                        sys_rst,
  input  logic [$clog2(NUM_LEDS):0]   current_position,
  input  logic [23:0]                 color_on,
  input  logic [1:0]                  mode,
  input  logic                        start_frame,
  output logic                        signal_out,
  output logic                        busy,
  output logic                        frame_done
);

  // Index shares the position width so idx/pos compare without extension.
  localparam int PW  = $clog2(NUM_LEDS) + 1;
  localparam int LCW = $clog2(LATCH_CYCLES + 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   pos_q, pos_d;
  color_t          color_q, color_d;
  mode_e           mode_q, mode_d;
  logic [PW-1:0]   idx_q, idx_d;
  logic [LCW-1:0]  cnt_q, cnt_d;
  color_t          rgb_q, rgb_d;

  logic            valid_in;
  logic            finished_led;

  function automatic color_t pixel_color(input logic [PW-1:0] idx,
                                         input logic [PW-1:0] pos,
                                         input color_t        c,
                                         input mode_e         m);
    color_t      px;
    int unsigned k;
    px = COLOR_OFF;
    k  = 0;
    case (m)
      MODE_DOT:  if (idx == pos) px = c;
      MODE_FILL: if (idx <= pos) px = c;
      MODE_TAIL: begin
        if (idx == pos) begin
          px = c;
        end else if (pos > idx) begin
          // Only pixels below the head are dimmed, so no wrap past 0.
          k = 32'(pos - idx);
          if (k <= unsigned'(TAIL_LEN))
            px = {c[23:16] >> k, c[15:8] >> k, c[7:0] >> k};
        end
      end
      default: px = COLOR_OFF;
    endcase
    return px;
  endfunction

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      color_q <= COLOR_OFF;
      mode_q  <= MODE_DOT;
      idx_q   <= '0;
      cnt_q   <= '0;
      rgb_q   <= COLOR_OFF;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      color_q <= color_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rgb_q   <= rgb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    color_d = color_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rgb_d   = rgb_q;
    case (state_q)
      ST_IDLE: begin
        if (start_frame) begin
          pos_d   = current_position;
          color_d = color_on;
          mode_d  = mode_e'(mode);
          idx_d   = '0;
          // Same values that are being latched this edge.
          rgb_d   = pixel_color('0, current_position, color_on, mode_e'(mode));
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (finished_led) begin
          if (idx_q < PW'(NUM_LEDS - 1)) begin
            idx_d   = idx_q + 1'b1;
            rgb_d   = pixel_color(idx_q + 1'b1, pos_q, color_q, mode_q);
            state_d = ST_LOAD;
          end else begin
            cnt_d   = '0;
            state_d = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        // Entry cycle plus LATCH_CYCLES counted clocks: the line stays low
        // for at least LATCH_CYCLES before frame_done.
        if (cnt_q == LCW'(LATCH_CYCLES)) state_d = ST_DONE;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign valid_in   = (state_q == ST_LOAD);
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_WAIT) || (state_q == ST_LATCH);
  assign frame_done = (state_q == ST_DONE);

  led_driver #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES)
  ) u_led_driver (
    .clk_in       (clk_100mhz),
    .rst_in       (sys_rst),
    .rgb_in       (rgb_q),
    .valid_in     (valid_in),
    .signal_out   (signal_out),
    .finished_led (finished_led)
  );

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Bench for led_frame_sequencer: decodes the serial line back into pixels
// and compares them with a pattern model; also times frame_done.
module tb_led_frame_sequencer;

  localparam int NUM_LEDS   = 10;
  localparam int TAIL_LEN   = 3;
  localparam int LATCH      = 5000;
  localparam int BIT_CYC    = 4;
  localparam int T0H        = 1;
  localparam int T1H        = 3;
  // One LOAD cycle, 24 bit slots, one cycle for finished_led to be seen.
  localparam int PIX_T      = 24 * BIT_CYC + 2;
  localparam int FRAME_T    = NUM_LEDS * PIX_T + LATCH + 3;
  localparam int PW         = $clog2(NUM_LEDS) + 1;

  logic          clk_100mhz = 1'b0;
  logic          sys_rst;
  logic [PW-1:0] current_position;
  logic [23:0]   color_on;
  logic [1:0]    mode;
  logic          start_frame;
  logic          signal_out;
  logic          busy;
  logic          frame_done;

  always #5 clk_100mhz = ~clk_100mhz;

  led_frame_sequencer #(
    .NUM_LEDS     (NUM_LEDS),
    .TAIL_LEN     (TAIL_LEN),
    .LATCH_CYCLES (LATCH),
    .BIT_CYCLES   (BIT_CYC),
    .T0H_CYCLES   (T0H),
    .T1H_CYCLES   (T1H)
  ) dut (
    .clk_100mhz       (clk_100mhz),
    .sys_rst          (sys_rst),
    .current_position (current_position),
    .color_on         (color_on),
    .mode             (mode),
    .start_frame      (start_frame),
    .signal_out       (signal_out),
    .busy             (busy),
    .frame_done       (frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Line monitor
  logic [23:0] pix_q[$];
  int          done_t[$];
  int          cyc = 0;
  int          hi_run = 0;
  int          low_run = 0;
  int          nbits = 0;
  logic [23:0] acc = '0;
  logic        prev = 1'b0;
  int          valid_cnt = 0;
  int          done_cnt = 0;
  int          last_gap = 0;

  always @(negedge clk_100mhz) begin
    cyc++;
    if (sys_rst) begin
      hi_run = 0; nbits = 0; acc = '0; prev = 1'b0; low_run = 0;
    end else begin
      if (signal_out) begin
        hi_run++;
        low_run = 0;
      end else begin
        low_run++;
        if (prev) begin
          acc = {acc[22:0], (hi_run >= 2)};
          hi_run = 0;
          nbits++;
          if (nbits == 24) begin
            pix_q.push_back(acc);
            nbits = 0;
          end
        end
      end
      if (dut.valid_in) valid_cnt++;
      if (frame_done) begin
        done_cnt++;
        done_t.push_back(cyc);
        last_gap = low_run;
      end
      prev = signal_out;
    end
  end

  // Pattern model
  function automatic logic [23:0] ref_pixel(input int idx, input int pos,
                                            input logic [23:0] c, input int m);
    int k;
    logic [7:0] g, r, b;
    k = pos - idx;
    g = c[23:16]; r = c[15:8]; b = c[7:0];
    case (m)
      0: return (k == 0) ? c : 24'h0;
      1: return (k >= 0) ? c : 24'h0;
      2: begin
        if (k == 0) return c;
        if (k >= 1 && k <= TAIL_LEN) return {g >> k, r >> k, b >> k};
        return 24'h0;
      end
      default: return 24'h0;
    endcase
  endfunction

  task automatic wait_done(input int d0, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_100mhz);
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_frame(input int pos, input logic [23:0] c, input int m, input string tag);
    int n;
    chk({tag, "_npix"}, pix_q.size(), NUM_LEDS);
    chk({tag, "_nvalid"}, valid_cnt, NUM_LEDS);
    chk({tag, "_gap"}, 32'(last_gap >= LATCH), 1);
    n = (pix_q.size() < NUM_LEDS) ? pix_q.size() : NUM_LEDS;
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_px%0d", tag, i), pix_q[i], ref_pixel(i, pos, c, m));
  endtask

  task automatic run_frame(input int pos, input logic [23:0] c, input int m, input string tag);
    int d0;
    bit ok;
    pix_q.delete();
    valid_cnt = 0;
    d0 = done_cnt;
    current_position = PW'(pos);
    color_on = c;
    mode = 2'(m);
    start_frame = 1'b1;
    @(negedge clk_100mhz);
    start_frame = 1'b0;
    wait_done(d0, 3 * FRAME_T, ok);
    chk({tag, "_done"}, 32'(ok), 1);
    repeat (3) @(negedge clk_100mhz);
    chk({tag, "_once"}, done_cnt - d0, 1);
    check_frame(pos, c, m, tag);
  endtask

  initial begin
    int d0;
    bit ok;
    int pos0;
    logic [23:0] c0;
    int m0;

    sys_rst = 1'b1;
    current_position = '0;
    color_on = '0;
    mode = '0;
    start_frame = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_line", 32'(signal_out), 0);
    sys_rst = 1'b0;
    repeat (2) @(negedge clk_100mhz);

    run_frame(3, 24'h00FF00, 0, "dot3");
    run_frame(12, 24'h123456, 1, "fill12");
    run_frame(12, 24'hABCDEF, 0, "dot12");
    run_frame(1, 24'h8040FF, 2, "tail1");

    // Mid-frame input changes and a repeated start are ignored.
    pix_q.delete();
    valid_cnt = 0;
    d0 = done_cnt;
    current_position = PW'(5);
    color_on = 24'h55AA11;
    mode = 2'd1;
    start_frame = 1'b1;
    @(negedge clk_100mhz);
    start_frame = 1'b0;
    repeat (300) @(negedge clk_100mhz);
    current_position = PW'(0);
    color_on = 24'hFFFFFF;
    mode = 2'd2;
    start_frame = 1'b1;
    repeat (5) @(negedge clk_100mhz);
    start_frame = 1'b0;
    wait_done(d0, 3 * FRAME_T, ok);
    chk("mid_done", 32'(ok), 1);
    repeat (20) @(negedge clk_100mhz);
    chk("mid_once", done_cnt - d0, 1);
    chk("mid_idle", 32'(busy), 0);
    check_frame(5, 24'h55AA11, 1, "mid");

    // Reset in the middle of pixel 5.
    pix_q.delete();
    valid_cnt = 0;
    current_position = PW'(9);
    color_on = 24'h123456;
    mode = 2'd1;
    start_frame = 1'b1;
    @(negedge clk_100mhz);
    start_frame = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 * PIX_T; i++) begin
      @(negedge clk_100mhz);
      if (pix_q.size() >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst5_reach", 32'(ok), 1);
    repeat (BIT_CYC * 3) @(negedge clk_100mhz);
    d0 = done_cnt;
    sys_rst = 1'b1;
    @(negedge clk_100mhz);
    chk("rst5_busy", 32'(busy), 0);
    chk("rst5_done", 32'(frame_done), 0);
    chk("rst5_line", 32'(signal_out), 0);
    @(negedge clk_100mhz);
    sys_rst = 1'b0;
    repeat (LATCH + 6 * PIX_T) @(negedge clk_100mhz);
    chk("rst5_nodone", done_cnt - d0, 0);
    chk("rst5_idle", 32'(busy), 0);
    run_frame(9, 24'h123456, 1, "post_rst");

    // start_frame held high: back-to-back frames.
    done_t.delete();
    d0 = done_cnt;
    current_position = PW'(7);
    color_on = 24'h0F0F0F;
    mode = 2'd0;
    start_frame = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4 * FRAME_T; i++) begin
      @(negedge clk_100mhz);
      if (done_cnt - d0 >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    start_frame = 1'b0;
    chk("b2b_three", 32'(ok), 1);
    chk("b2b_ndone", done_t.size(), 3);
    if (done_t.size() >= 3) begin
      chk("b2b_space0", done_t[1] - done_t[0], FRAME_T);
      chk("b2b_space1", done_t[2] - done_t[1], FRAME_T);
    end
    repeat (3 * PIX_T) @(negedge clk_100mhz);
    chk("b2b_stop", 32'(busy), 0);

    // Random patterns.
    for (int t = 0; t < 2; t++) begin
      pos0 = int'($urandom_range(0, 13));
      c0   = 24'($urandom);
      m0   = int'($urandom_range(0, 3));
      run_frame(pos0, c0, m0, $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_frame_sequencer.md
LED_FRAME_SEQUENCER -- requirements
Module: led_frame_sequencer

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 10, meaning the number of LEDs per frame (valid range 1..1023).
REQ-002 SHALL have parameter TAIL_LEN, default 3, meaning the number of dimmed LEDs trailing the head in TAIL mode (valid range 0..7).
REQ-003 SHALL have parameter LATCH_CYCLES, default 5000, meaning the line-low latch gap after a frame, in clocks (5000 = 50 us at 100 MHz).
REQ-004 SHALL have port clk_100mhz, input, 1 bit: the only clock.
REQ-005 SHALL have port sys_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port current_position, input, $clog2(NUM_LEDS)+1 bits: head index, 0-based.
REQ-007 SHALL have port color_on, input, 24 bits: lit colour, GRB order, G in [23:16].
REQ-008 SHALL have port mode, input, 2 bits: 0 DOT, 1 FILL, 2 TAIL, 3 OFF.
REQ-009 SHALL have port start_frame, input, 1 bit: frame request, level or pulse.
REQ-010 SHALL have port signal_out, output, 1 bit: serial LED data line.
REQ-011 SHALL have port busy, output, 1 bit: high from frame acceptance until frame_done.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of the latch gap.

Function
REQ-013 SHALL use states IDLE, LOAD, WAIT, LATCH and DONE.
REQ-014 In IDLE with start_frame=1, SHALL latch current_position, color_on and mode, clear led_idx to 0, set busy and go to LOAD.
REQ-015 In LOAD, SHALL drive the pixel colour for led_idx to the led_driver with valid_in=1 for exactly one cycle, then go to WAIT.
REQ-016 In WAIT on finished_led=1: SHALL go to LOAD with led_idx+1 if led_idx<NUM_LEDS-1; otherwise SHALL clear the latch counter and go to LATCH.
REQ-017 In LATCH, SHALL hold valid_in=0, count LATCH_CYCLES clocks, then go to DONE.
REQ-018 In DONE, SHALL pulse frame_done=1 and clear busy in the same cycle, then go to IDLE.
REQ-019 Pixel colours: DOT lights only idx==pos; FILL lights idx<=pos; TAIL lights pos with color_on and pos-k (k=1..TAIL_LEN, pos-k>=0) with each 8-bit channel of color_on shifted right by k; all other pixels and OFF mode are 24'h000000.
REQ-020 Pixel colour SHALL be computed from the latched values only; input changes mid-frame SHALL have no effect.
REQ-021 start_frame while busy SHALL be ignored and not queued; start_frame held high in DONE SHALL start the next frame from IDLE one cycle later.
REQ-022 pos>=NUM_LEDS: DOT and TAIL heads SHALL light nothing (in-range tail pixels still lit); FILL SHALL light all LEDs.
REQ-023 TAIL pixels SHALL NOT wrap below index 0.
REQ-024 The led_idx and latch counters SHALL be wide enough for NUM_LEDS-1 and LATCH_CYCLES without overflow.
REQ-025 Exactly NUM_LEDS valid_in pulses SHALL be issued per frame.

Reset
REQ-026 On sys_rst=1, at any time, SHALL go to IDLE with busy=0, frame_done=0, valid_in=0, led_idx=0, counters=0 and signal_out=0.
REQ-027 Reset mid-frame SHALL abort the frame without a frame_done pulse; the first frame after release SHALL start at idx 0.

Structure
REQ-028 Package led_pkg SHALL hold the mode enum (DOT/FILL/TAIL/OFF), the state enum, the 24-bit GRB colour typedef and the COLOR_OFF constant.
REQ-029 SHALL instantiate one existing led_driver (clk_in, rst_in, rgb_in, valid_in, signal_out, finished_led) as its sole sub-module.
REQ-030 SHALL register rgb_in so it is stable during the valid_in pulse and the following WAIT.

Verification
REQ-031 Bench SHALL check: DOT, NUM_LEDS=10, pos=3, color_on=24'h00FF00 -> only pixel 3 is 00FF00, 10 valid pulses, one frame_done after ≥5000 low cycles.
REQ-032 Bench SHALL check: FILL, pos=12, NUM_LEDS=10 -> all 10 pixels lit; DOT with pos=12 -> all 10 pixels off.
REQ-033 Bench SHALL check: TAIL, TAIL_LEN=3, pos=1, color_on=24'h8040FF -> pixel1=8040FF, pixel0=40207F, pixels 2..9 off, no wrap.
REQ-034 Bench SHALL check: start_frame re-asserted and mode/color_on changed mid-frame -> no effect on the current frame, a single frame_done.
REQ-035 Bench SHALL check: sys_rst asserted at pixel 5 -> immediate IDLE, no frame_done; the next start produces a full 10-pixel frame.
REQ-036 Bench SHALL check: start_frame held high -> back-to-back frames, frame_done spacing = 10×pixel time + 5000 + 3 fixed overhead cycles.
